// File: rtl/unpool_upsample2x_if.sv
// Pixel stream bundle: valid/ready handshake, pixel data and end-of-frame marker.
interface unpool_upsample2x_if #(
  parameter int unsigned DataW = 32
) ();
  logic             valid;
  logic             ready;
  logic [DataW-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/unpool_upsample2x.sv
// Nearest-neighbour 2x upsampler: each input pixel becomes a 2x2 block of the output raster.
// Even output rows are emitted straight from a hold register while the row is captured into a
// row buffer; the odd output row is then replayed from that buffer.
module unpool_upsample2x #(
  parameter int unsigned In_d_W = 32,
  parameter int unsigned W_IN   = 13,
  parameter int unsigned H_IN   = 13
) (
  input logic                  iClk,
  input logic                  iRsn,
  unpool_upsample2x_if.slave   in_if,
  unpool_upsample2x_if.master  out_if
);

  localparam int unsigned ColW = $clog2(W_IN);
  localparam int unsigned RowW = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(W_IN - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(H_IN - 1);

  typedef enum logic [1:0] {StIdle, StDup, StRep} state_e;

  state_e              state_q, state_d;
  logic [ColW-1:0]     in_col_q, in_col_d;
  logic [RowW-1:0]     in_row_q, in_row_d;
  logic [ColW-1:0]     rep_col_q, rep_col_d;
  logic                beat_q, beat_d;
  logic [In_d_W-1:0]   hold_q, hold_d;
  logic [In_d_W-1:0]   rowbuf_q [W_IN];

  logic                wr_en;
  logic                in_ready;
  logic                out_valid;
  logic [In_d_W-1:0]   out_data;

  // Next-state, counters and output decode; outputs depend on state only.
  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    rep_col_d = rep_col_q;
    beat_d    = beat_q;
    hold_d    = hold_q;
    wr_en     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_if.valid) begin
          hold_d  = in_if.data;
          wr_en   = 1'b1;
          beat_d  = 1'b0;
          state_d = StDup;
        end
      end
      StDup: begin
        out_valid = 1'b1;
        out_data  = hold_q;
        if (out_if.ready) begin
          if (!beat_q) begin
            beat_d = 1'b1;
          end else begin
            beat_d = 1'b0;
            if (in_col_q != ColLast) begin
              in_col_d = in_col_q + ColW'(1);
              state_d  = StIdle;
            end else begin
              // Row captured: replay follows with no idle cycle in between.
              in_col_d  = '0;
              rep_col_d = '0;
              state_d   = StRep;
            end
          end
        end
      end
      StRep: begin
        out_valid = 1'b1;
        out_data  = rowbuf_q[rep_col_q];
        if (out_if.ready) begin
          beat_d = ~beat_q;
          if (beat_q) begin
            if (rep_col_q != ColLast) begin
              rep_col_d = rep_col_q + ColW'(1);
            end else begin
              in_row_d = (in_row_q == RowLast) ? '0 : in_row_q + RowW'(1);
              state_d  = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and hold register.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= StIdle;
      in_col_q  <= '0;
      in_row_q  <= '0;
      rep_col_q <= '0;
      beat_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      rep_col_q <= rep_col_d;
      beat_q    <= beat_d;
      hold_q    <= hold_d;
    end
  end

  // Row buffer; contents are don't-care after reset so it needs no reset.
  always_ff @(posedge iClk) begin
    if (wr_en) begin
      rowbuf_q[in_col_q] <= in_if.data;
    end
  end

  // Ready is forced low while reset is asserted.
  assign in_if.ready  = in_ready & iRsn;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_data;
  assign out_if.last  = (state_q == StRep) & beat_q & (rep_col_q == ColLast) &
                        (in_row_q == RowLast);

endmodule

// File: tb/tb_unpool_upsample2x.sv
// Scoreboard bench: a 2x2 instance for sequence/stall/reset/wrap cases, a 13x13 instance for
// the full-size ramp. Stimulus pushes expected beats; negedge monitors pop and compare.
module tb_unpool_upsample2x;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  unpool_upsample2x_if #(.DataW(32)) a_in  ();
  unpool_upsample2x_if #(.DataW(32)) a_out ();
  unpool_upsample2x_if #(.DataW(32)) b_in  ();
  unpool_upsample2x_if #(.DataW(32)) b_out ();

  unpool_upsample2x #(.In_d_W(32), .W_IN(2), .H_IN(2)) dut_a (
    .iClk  (clk),
    .iRsn  (rst_n),
    .in_if (a_in),
    .out_if(a_out)
  );

  unpool_upsample2x #(.In_d_W(32), .W_IN(13), .H_IN(13)) dut_b (
    .iClk  (clk),
    .iRsn  (rst_n),
    .in_if (b_in),
    .out_if(b_out)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output-ready driver for instance a: 0 = always ready, 1 = random, 2 = held low.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       a_out.ready = 1'b1;
      1:       a_out.ready = 1'($urandom_range(0, 1));
      default: a_out.ready = 1'b0;
    endcase
  end

  // Monitor for instance a: data/last, stall stability, 1-cycle latency, frame-wrap ready.
  logic        prev_stall  = 1'b0;
  logic [31:0] prev_data   = '0;
  logic        prev_last   = 1'b0;
  logic        prev_in_acc = 1'b0;
  logic        exp_rdy     = 1'b0;
  int          n_out_a     = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 1'b0;
      prev_in_acc = 1'b0;
      exp_rdy     = 1'b0;
    end else begin
      if (prev_in_acc) check("a_latency_valid", 32'(a_out.valid), 32'd1);
      if (exp_rdy) check("a_wrap_in_ready", 32'(a_in.ready), 32'd1);
      exp_rdy = 1'b0;
      if (prev_stall) begin
        check("a_stall_valid", 32'(a_out.valid), 32'd1);
        check("a_stall_data", a_out.data, prev_data);
        check("a_stall_last", 32'(a_out.last), 32'(prev_last));
      end
      if (a_out.valid && a_out.ready) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_beat: got %h expected none", a_out.data);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          check("a_data", a_out.data, e.d);
          check("a_last", 32'(a_out.last), 32'(e.l));
        end
        n_out_a++;
        if (a_out.last) exp_rdy = 1'b1;
      end
      prev_stall  = a_out.valid & ~a_out.ready;
      prev_data   = a_out.data;
      prev_last   = a_out.last;
      prev_in_acc = a_in.valid & a_in.ready;
    end
  end

  // Monitor for instance b.
  int n_out_b  = 0;
  int n_last_b = 0;
  always @(negedge clk) begin
    if (rst_n && b_out.valid && b_out.ready) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_beat: got %h expected none", b_out.data);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", b_out.data, e.d);
        check("b_last", 32'(b_out.last), 32'(e.l));
      end
      n_out_b++;
      if (b_out.last) n_last_b++;
    end
  end

  task automatic send_a(input logic [31:0] d);
    int n = 0;
    a_in.valid = 1'b1;
    a_in.data  = d;
    while (!a_in.ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!a_in.ready) begin
      checks++;
      errors++;
      $display("FAIL a_send_timeout: got no ready expected ready within 500 cycles");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_b(input logic [31:0] d);
    int n = 0;
    b_in.valid = 1'b1;
    b_in.data  = d;
    while (!b_in.ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!b_in.ready) begin
      checks++;
      errors++;
      $display("FAIL b_send_timeout: got no ready expected ready within 500 cycles");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // 2x2 frame: push the 16 expected beats, then feed the 4 pixels (optional input gaps).
  task automatic frame_a(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input int gap);
    logic [31:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        exp_t e;
        e.d = p[(r / 2) * 2 + c / 2];
        e.l = (r == 3) && (c == 3);
        q_a.push_back(e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_a(p[i]);
      if (gap > 0) begin
        a_in.valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic drain_a();
    int n = 0;
    a_in.valid = 1'b0;
    while (q_a.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_a.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL a_drain_timeout: got %0d pending expected 0", q_a.size());
      q_a.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in.valid  = 1'b0;
    a_in.data   = '0;
    a_in.last   = 1'b0;
    b_in.valid  = 1'b0;
    b_in.data   = '0;
    b_in.last   = 1'b0;
    b_out.ready = 1'b1;

    // Reset state.
    repeat (3) begin @(posedge clk); end
    #1;
    check("rst_a_in_ready", 32'(a_in.ready), 32'd0);
    check("rst_a_out_valid", 32'(a_out.valid), 32'd0);
    check("rst_a_out_data", a_out.data, 32'd0);
    check("rst_a_out_last", 32'(a_out.last), 32'd0);
    check("rst_b_in_ready", 32'(b_in.ready), 32'd0);
    check("rst_b_out_valid", 32'(b_out.valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_a_in_ready", 32'(a_in.ready), 32'd1);
    check("idle_a_out_valid", 32'(a_out.valid), 32'd0);

    // 1) basic 2x2 with output always ready.
    rdy_mode = 0;
    frame_a(32'd1, 32'd2, 32'd3, 32'd4, 0);
    drain_a();

    // 3) random output stalls plus input gaps: same sequence, stable data while stalled.
    rdy_mode = 1;
    frame_a(32'd1, 32'd2, 32'd3, 32'd4, 2);
    drain_a();

    // 4) negative / sign-bit patterns pass through untouched.
    frame_a(32'hFFFF_FFF0, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 0);
    drain_a();
    rdy_mode = 0;

    // 5) reset after 5 outputs of a frame, then a full frame restarting at pixel (0,0).
    begin
      exp_t e;
      int base;
      int n;
      logic [31:0] part [5];
      part[0] = 32'd9; part[1] = 32'd9; part[2] = 32'd8; part[3] = 32'd8; part[4] = 32'd9;
      for (int i = 0; i < 5; i++) begin
        e.d = part[i];
        e.l = 1'b0;
        q_a.push_back(e);
      end
      base = n_out_a;
      send_a(32'd9);
      send_a(32'd8);
      a_in.valid = 1'b0;
      n = 0;
      while (n_out_a < base + 5 && n < 200) begin
        @(posedge clk); #2;
        n++;
      end
      check("rst_mid_outcount", 32'(n_out_a - base), 32'd5);
      rdy_mode    = 2;
      a_out.ready = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("rst_mid_in_ready", 32'(a_in.ready), 32'd0);
      check("rst_mid_out_valid", 32'(a_out.valid), 32'd0);
      check("rst_mid_out_last", 32'(a_out.last), 32'd0);
      q_a.delete();
      repeat (2) begin @(posedge clk); end
      #2 rst_n = 1'b1;
      rdy_mode = 0;
      @(posedge clk); #1;
      frame_a(32'd5, 32'd6, 32'd7, 32'd8, 0);
      drain_a();
    end

    // 6) two back-to-back frames with input valid held high.
    frame_a(32'h11, 32'h22, 32'h33, 32'h44, 0);
    frame_a(32'h55, 32'h66, 32'h77, 32'h88, 0);
    drain_a();

    // 2) 13x13 ramp on instance b.
    begin
      int n = 0;
      for (int r = 0; r < 26; r++) begin
        for (int c = 0; c < 26; c++) begin
          exp_t e;
          e.d = 32'((r / 2) * 13 + c / 2);
          e.l = (r == 25) && (c == 25);
          q_b.push_back(e);
        end
      end
      for (int i = 0; i < 169; i++) send_b(32'(i));
      b_in.valid = 1'b0;
      while (q_b.size() != 0 && n < 5000) begin
        @(posedge clk); #1;
        n++;
      end
      check("b_pending", 32'(q_b.size()), 32'd0);
      check("b_outcount", 32'(n_out_b), 32'd676);
      check("b_last_count", 32'(n_last_b), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
